// File: rtl/ram_n_sweep.sv
// Parametrised single-port RAM with combinational read and a hardware clear engine
// that zeroes every word, one address per cycle, after reset or on request.
module ram_n_sweep #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  val,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              done,
  output logic              wr_dropped
);

  localparam int unsigned       DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = val;
    case (state_q)
      StIdle: begin
        if (clear) begin
          // clear outranks a simultaneous write
          state_d = StSweep;
          ptr_d   = '0;
          drop_d  = load;
        end else if (load) begin
          mem_we = 1'b1;
        end
      end
      StSweep: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = '0;
        drop_d    = load;
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == LastPtr) begin
          state_d = StIdle;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = StSweep;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StSweep;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // Storage has no reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  assign busy       = (state_q == StSweep);
  assign done       = done_q;
  assign wr_dropped = drop_q;
  assign out        = busy ? '0 : mem_q[address];

endmodule

// File: tb/tb_ram_n_sweep.sv
// Directed self-checking bench for ram_n_sweep (WIDTH=16, ADDR_W=3).
module tb_ram_n_sweep;

  logic        clk;
  logic        reset;
  logic [15:0] val;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic        done;
  logic        wr_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  ram_n_sweep #(
    .WIDTH  (16),
    .ADDR_W (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .val        (val),
    .load       (load),
    .address    (address),
    .clear      (clear),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .wr_dropped (wr_dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; val = '0; load = 1'b0; address = '0; clear = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || out !== 16'h0000 || done !== 1'b0 || wr_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b out=%h done=%b drop=%b, want 1 0000 0 0",
               busy, out, done, wr_dropped);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (i < 8) begin
        if (busy !== 1'b1 || out !== 16'h0000 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_sweep edge %0d: busy=%b out=%h done=%b, want 1 0000 0",
                   i, busy, out, done);
        end
      end else if (busy !== 1'b0 || done !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_sweep_end: busy=%b done=%b, want 0 1", busy, done);
      end
    end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_checks++;
      if (out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got %h want 0000", a, out);
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done_width: done=%b want 0", done);
    end
  endtask

  task automatic test_write();
    load = 1'b1; address = 3'b011; val = 16'h0003;
    tick();
    n_checks++;
    if (wr_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL write_drop0: got %b want 0", wr_dropped);
    end
    address = 3'b101; val = 16'h000F;
    tick();
    n_checks++;
    if (wr_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL write_drop1: got %b want 0", wr_dropped);
    end
    load = 1'b0;
    address = 3'b011; #1;
    n_checks++;
    if (out !== 16'h0003) begin
      n_fail++;
      $display("FAIL write_read011: got %h want 0003", out);
    end
    address = 3'b101; #1;
    n_checks++;
    if (out !== 16'h000F) begin
      n_fail++;
      $display("FAIL write_read101: got %h want 000f", out);
    end
    address = 3'b000; #1;
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL write_read000: got %h want 0000", out);
    end
  endtask

  task automatic test_clear_idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || wr_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_start: busy=%b drop=%b, want 1 0", busy, wr_dropped);
    end
    load = 1'b1; val = 16'hFFFF; address = 3'b010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (wr_dropped !== 1'b1 || busy !== (i < 8) || done !== (i == 8)) begin
        n_fail++;
        $display("FAIL clear_sweep edge %0d: drop=%b busy=%b done=%b", i, wr_dropped, busy,
                 done);
      end
    end
    load = 1'b0;
    address = 3'b010; #1;
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_read010: got %h want 0000", out);
    end
    address = 3'b011; #1;
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_read011: got %h want 0000", out);
    end
    address = 3'b101; #1;
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_read101: got %h want 0000", out);
    end
  endtask

  task automatic test_clear_restart();
    int done_cnt = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) clear = 1'b1;
      tick();
      if (done === 1'b1) done_cnt++;
    end
    clear = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      n_checks++;
      if (busy !== (i < 8)) begin
        n_fail++;
        $display("FAIL restart_busy edge %0d: got %b want %b", i, busy, (i < 8));
      end
    end
    tick();
    if (done === 1'b1) done_cnt++;
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL restart_done_count: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_load_and_clear();
    load = 1'b1; address = 3'b001; val = 16'hABCD;
    tick();
    load = 1'b0; #1;
    n_checks++;
    if (out !== 16'hABCD) begin
      n_fail++;
      $display("FAIL lc_prewrite: got %h want abcd", out);
    end
    load = 1'b1; clear = 1'b1; val = 16'h1234;
    tick();
    load = 1'b0; clear = 1'b0;
    n_checks++;
    if (wr_dropped !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lc_drop: drop=%b busy=%b, want 1 1", wr_dropped, busy);
    end
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL lc_after: done=%b busy=%b out=%h, want 1 0 0000", done, busy, out);
    end
  endtask

  task automatic test_async_reset();
    int done_cnt = 0;
    load = 1'b1; address = 3'b110; val = 16'h5A5A;
    tick();
    load = 1'b0; #1;
    n_checks++;
    if (out !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL ar_prewrite: got %h want 5a5a", out);
    end
    // Assert reset between edges while idle: out must drop at once.
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b1 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL ar_idle_immediate: busy=%b out=%h, want 1 0000", busy, out);
    end
    tick();
    reset = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b1 || out !== 16'h0000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_sweep_immediate: busy=%b out=%h done=%b", busy, out, done);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      n_checks++;
      if (busy !== (i < 8)) begin
        n_fail++;
        $display("FAIL ar_sweep_busy edge %0d: got %b want %b", i, busy, (i < 8));
      end
    end
    tick();
    if (done === 1'b1) done_cnt++;
    n_checks++;
    if (done_cnt != 1 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL ar_done_count: count=%0d out=%h, want 1 0000", done_cnt, out);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_clear_idle();
    test_clear_restart();
    test_load_and_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_n_sweep.md
Name: ram_n_sweep

Overview:
- Parametrised successor to the fixed 8-word, 16-bit RAM: width and depth are configurable.
- Adds an asynchronous active-high reset and a hardware clear engine. After reset, or on a clear request, the engine zeroes every word one address per cycle, and `busy` flags the sweep.
- Sits wherever the design needs a small general register-file RAM whose contents must be guaranteed known after reset.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- val  input  WIDTH  write data.
- load  input  1  write enable, sampled at rising clk.
- address  input  ADDR_W  read/write address.
- clear  input  1  request full-memory zeroing, sampled at rising clk.
- out  output  WIDTH  read data.
- busy  output  1  high while the sweep runs.
- done  output  1  one-cycle pulse when a sweep completes.
- wr_dropped  output  1  one-cycle pulse when a write was refused.

Behaviour:
- Reset is asynchronous and active-high; it acts immediately, independent of clk.
  - Reset values: state=SWEEP, ptr=0, busy=1, done=0, wr_dropped=0.
  - out=0, because busy gates it.
  - Memory contents are not touched by reset itself; the sweep clears them.
- States: IDLE, SWEEP. `busy` is a registered output equal to (state==SWEEP).
- SWEEP, each rising edge:
  - mem[ptr]<=0; ptr<=ptr+1.
  - When ptr==DEPTH-1: that edge writes the last word, state<=IDLE, ptr<=0, done<=1 for exactly one cycle.
  - A sweep therefore takes exactly DEPTH edges after reset release or after the clear edge.
- clear while in SWEEP: the sweep restarts, ptr<=0, and no done pulse is issued for the aborted sweep.
- clear while in IDLE: state<=SWEEP, ptr<=0, busy rises on the next edge. The first zeroing write (address 0) happens on the edge after clear is sampled.
- load in IDLE with clear=0: mem[address]<=val at the rising edge.
- Refused writes: load is refused, with wr_dropped<=1 for one cycle and memory unchanged, when:
  - load=1 while in SWEEP, or
  - load=1 in the same edge as clear=1. clear has priority.
- Read path is combinational: out = busy ? 0 : mem[address].
  - A write becomes visible on out immediately after the writing edge.
  - Before that edge, out shows the old word.
- done and wr_dropped are registered and default to 0 on every edge unless set as above.
- Reset asserted mid-sweep or mid-write: the FSM returns to SWEEP with ptr=0 and the sweep restarts from address 0 after release. A write on the same edge as reset assertion is lost.
- Address arithmetic: ptr is ADDR_W bits wide, with no wrap beyond DEPTH-1. address always maps to a valid word, so there is no out-of-range case.
- No X may ever appear on out after the first completed sweep.

Test Plan (WIDTH=16, ADDR_W=3):
- Assert reset for 2 cycles, then release -> busy=1 and out=0 for 8 rising edges; done=1 for the one cycle after the 8th edge; busy=0 after it; reading addresses 0..7 returns 16'h0000 each.
- After the sweep, write 16'h0003 to addr 3'b011, then 16'h000F to 3'b101 with load=1 on consecutive edges; set load=0 -> reading 011 gives 16'h0003, reading 101 gives 16'h000F, reading 000 gives 16'h0000; wr_dropped stays 0.
- Pulse clear in IDLE after the writes above; hold load=1 with val=16'hFFFF, addr 3'b010 during the sweep -> wr_dropped=1 on each sweep cycle; after done, addresses 010, 011 and 101 all read 16'h0000.
- Pulse clear again at the 4th sweep edge -> busy stays high for 8 further edges; exactly one done pulse total.
- Assert load=1 and clear=1 on the same edge in IDLE (val=16'h1234, addr 3'b001) -> wr_dropped=1; after the sweep, addr 001 reads 16'h0000.
- Assert reset mid-sweep, asynchronously between edges -> busy=1 and out=0 immediately, without waiting for a clock edge; after release, a full 8-edge sweep and a single done pulse.
